// File: rtl/lp_piped_int_mult_if.sv
// lp_piped_int_mult_if: launch/arrive bundle for the piped integer multiplier.
// master = scheduler/consumer side, slave = multiplier side.
interface lp_piped_int_mult_if #(
   parameter int A_WIDTH  = 16,
   parameter int B_WIDTH  = 16,
   parameter int ID_WIDTH = 8,
   parameter int STAGES   = 4
);
   localparam int CNT_WIDTH = $clog2(STAGES + 1);

   logic [A_WIDTH-1:0]         a;
   logic [B_WIDTH-1:0]         b;
   logic                       tc;
   logic                       launch;
   logic [ID_WIDTH-1:0]        launch_id;
   logic                       pipe_full;
   logic                       pipe_ovf;
   logic                       accept_n;
   logic                       arrive;
   logic [ID_WIDTH-1:0]        arrive_id;
   logic                       push_out_n;
   logic [A_WIDTH+B_WIDTH-1:0] z;
   logic [CNT_WIDTH-1:0]       pipe_census;

   modport master (
      output a, b, tc, launch, launch_id, accept_n,
      input  pipe_full, pipe_ovf, arrive, arrive_id, push_out_n, z, pipe_census
   );

   modport slave (
      input  a, b, tc, launch, launch_id, accept_n,
      output pipe_full, pipe_ovf, arrive, arrive_id, push_out_n, z, pipe_census
   );
endinterface

// File: rtl/lp_piped_int_mult.sv
// lp_piped_int_mult: low-power pipelined integer multiplier with bubble
// collapse, ID tracking, census and full/overflow flags.
// Optional macro LP_PIPED_INT_MULT_OUT_ISO_EN: zero z/arrive_id when arrive=0.
module lp_piped_int_mult #(
   parameter int A_WIDTH  = 16,
   parameter int B_WIDTH  = 16,
   parameter int ID_WIDTH = 8,
   parameter int STAGES   = 4
) (
   input  logic               clk,
   input  logic               rst,
   lp_piped_int_mult_if.slave bus
);
   localparam int CNT_WIDTH = $clog2(STAGES + 1);
   localparam int P_WIDTH   = A_WIDTH + B_WIDTH;

   // slot state
   logic [STAGES-1:0]                r_vld_pipe;
   logic [STAGES-1:0][P_WIDTH-1:0]   r_prod;
   logic [STAGES-1:0][ID_WIDTH-1:0]  r_id;
   logic [CNT_WIDTH-1:0]             r_census;
   logic                             r_ovf;

   // per-slot control
   logic [STAGES-1:0]                w_adv;
   logic [STAGES-1:0]                w_load;
   logic [STAGES-1:0]                w_vld_nxt;
   logic [STAGES-1:0][P_WIDTH-1:0]   w_prod_in;
   logic [STAGES-1:0][ID_WIDTH-1:0]  w_id_in;

   logic [P_WIDTH-1:0] w_a_ext;
   logic [P_WIDTH-1:0] w_b_ext;
   logic [P_WIDTH-1:0] w_prod;
   logic               w_drain;
   logic               w_accept;
   logic               w_full;

   // Extending both operands to the full product width makes a single
   // modular multiply correct for both signed and unsigned modes.
   assign w_a_ext = {{B_WIDTH{bus.tc & bus.a[A_WIDTH-1]}}, bus.a};
   assign w_b_ext = {{A_WIDTH{bus.tc & bus.b[B_WIDTH-1]}}, bus.b};
   assign w_prod  = w_a_ext * w_b_ext;

   assign w_drain = r_vld_pipe[STAGES-1] & ~bus.accept_n;

   // Advance chain, resolved from the output slot backward so a slot can
   // move into a neighbour that is vacating in the same cycle.
   always_comb begin
      w_adv = '0;
      w_adv[STAGES-1] = w_drain;
      for (int i = STAGES - 2; i >= 0; i--) begin
         w_adv[i] = r_vld_pipe[i] & (~r_vld_pipe[i+1] | w_adv[i+1]);
      end
   end

   assign w_full   = r_vld_pipe[0] & ~w_adv[0];
   assign w_accept = bus.launch & ~w_full;

   // Slot 0 takes a new operation; later slots take from their predecessor.
   assign w_load[0]    = w_accept;
   assign w_prod_in[0] = w_prod;
   assign w_id_in[0]   = bus.launch_id;

   for (genvar i = 1; i < STAGES; i++) begin : g_slot
      assign w_load[i]    = w_adv[i-1];
      assign w_prod_in[i] = r_prod[i-1];
      assign w_id_in[i]   = r_id[i-1];
   end

   // A slot is occupied next cycle if it is loaded, or holds and does not move on.
   assign w_vld_nxt = w_load | (r_vld_pipe & ~w_adv);

   // Valid bits update every cycle; data/ID only on a real move to save toggles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_vld_pipe <= '0;
         r_prod     <= '0;
         r_id       <= '0;
      end else begin
         r_vld_pipe <= w_vld_nxt;
         for (int i = 0; i < STAGES; i++) begin
            if (w_load[i]) begin
               r_prod[i] <= w_prod_in[i];
               r_id[i]   <= w_id_in[i];
            end
         end
      end
   end

   // Occupancy count: accepted launch adds one, drain removes one.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_census <= '0;
      end else begin
         case ({w_accept, w_drain})
            2'b10:   r_census <= r_census + CNT_WIDTH'(1);
            2'b01:   r_census <= r_census - CNT_WIDTH'(1);
            default: r_census <= r_census;
         endcase
      end
   end

   // One-cycle overflow pulse for a launch dropped against a full pipe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_ovf <= 1'b0;
      else     r_ovf <= bus.launch & w_full;
   end

   assign bus.arrive      = r_vld_pipe[STAGES-1];
   assign bus.push_out_n  = ~w_drain;
   assign bus.pipe_full   = w_full;
   assign bus.pipe_ovf    = r_ovf;
   assign bus.pipe_census = r_census;

`ifdef LP_PIPED_INT_MULT_OUT_ISO_EN
   // Gate the result bus to zero while no result is presented.
   assign bus.z         = r_prod[STAGES-1] & {P_WIDTH{r_vld_pipe[STAGES-1]}};
   assign bus.arrive_id = r_id[STAGES-1] & {ID_WIDTH{r_vld_pipe[STAGES-1]}};
`else
   assign bus.z         = r_prod[STAGES-1];
   assign bus.arrive_id = r_id[STAGES-1];
`endif

endmodule

// File: tb/tb_lp_piped_int_mult.sv
// tb_lp_piped_int_mult: directed-vector bench for lp_piped_int_mult
// (STAGES=4, 8x8 operands, 8-bit IDs).
module tb_lp_piped_int_mult;
   localparam int AW = 8;
   localparam int BW = 8;
   localparam int IW = 8;
   localparam int ST = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   lp_piped_int_mult_if #(.A_WIDTH(AW), .B_WIDTH(BW), .ID_WIDTH(IW), .STAGES(ST)) bus ();

   lp_piped_int_mult #(.A_WIDTH(AW), .B_WIDTH(BW), .ID_WIDTH(IW), .STAGES(ST)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic tc,
                        input logic [7:0] id);
      bus.a         = a;
      bus.b         = b;
      bus.tc        = tc;
      bus.launch_id = id;
      bus.launch    = 1'b1;
   endtask

   task automatic idle();
      bus.launch = 1'b0;
   endtask

   task automatic do_reset();
      idle();
      bus.accept_n = 1'b1;
      rst = 1'b1;
      #1;
      step();
      rst = 1'b0;
   endtask

   initial begin
      bus.a = '0; bus.b = '0; bus.tc = 1'b0; bus.launch = 1'b0;
      bus.launch_id = '0; bus.accept_n = 1'b1;
      rst = 1'b1;
      #2;
      chk("rst_census", 32'(bus.pipe_census), 0);
      chk("rst_arrive", 32'(bus.arrive), 0);
      chk("rst_full",   32'(bus.pipe_full), 0);
      chk("rst_ovf",    32'(bus.pipe_ovf), 0);
      chk("rst_push_n", 32'(bus.push_out_n), 1);
      chk("rst_z",      32'(bus.z), 0);
      chk("rst_id",     32'(bus.arrive_id), 0);
      step();
      rst = 1'b0;

      // basic latency: 3*5 arrives 4 cycles after launch
      do_reset();
      drive(8'd3, 8'd5, 1'b0, 8'h11);
      bus.accept_n = 1'b0;
      #1;
      chk("lat_census0", 32'(bus.pipe_census), 0);
      step();
      for (int c = 1; c <= 5; c++) begin
         idle();
         #1;
         chk("lat_census", 32'(bus.pipe_census), (c <= 4) ? 1 : 0);
         chk("lat_arrive", 32'(bus.arrive), (c == 4) ? 1 : 0);
         chk("lat_push_n", 32'(bus.push_out_n), (c == 4) ? 0 : 1);
         if (c == 4) begin
            chk("lat_z",  32'(bus.z), 32'h000F);
            chk("lat_id", 32'(bus.arrive_id), 32'h11);
         end
         step();
      end

      // sign mode, back-to-back
      do_reset();
      bus.accept_n = 1'b0;
      for (int c = 0; c <= 6; c++) begin
         if (c == 0)      drive(8'hFF, 8'h02, 1'b1, 8'h21);
         else if (c == 1) drive(8'hFF, 8'h02, 1'b0, 8'h22);
         else             idle();
         #1;
         chk("sgn_arrive", 32'(bus.arrive), (c == 4 || c == 5) ? 1 : 0);
         if (c == 4) begin
            chk("sgn_z_tc1",  32'(bus.z), 32'hFFFE);
            chk("sgn_id_tc1", 32'(bus.arrive_id), 32'h21);
         end
         if (c == 5) begin
            chk("sgn_z_tc0",  32'(bus.z), 32'h01FE);
            chk("sgn_id_tc0", 32'(bus.arrive_id), 32'h22);
         end
         step();
      end

      // backpressure / overflow: ids 1..5, id 5 dropped, release at cycle 8
      do_reset();
      for (int c = 0; c <= 12; c++) begin
         int exp_cen;
         int exp_id;
         if (c <= 4) drive(8'(c + 1), 8'd2, 1'b0, 8'(c + 1));
         else        idle();
         bus.accept_n = (c >= 8) ? 1'b0 : 1'b1;
         #1;
         exp_cen = (c <= 4) ? c : (c <= 8) ? 4 : 12 - c;
         exp_id  = (c <= 8) ? 1 : c - 7;
         chk("bp_census", 32'(bus.pipe_census), 32'(exp_cen));
         chk("bp_full",   32'(bus.pipe_full), (c >= 4 && c <= 7) ? 1 : 0);
         chk("bp_ovf",    32'(bus.pipe_ovf), (c == 5) ? 1 : 0);
         chk("bp_arrive", 32'(bus.arrive), (c >= 4 && c <= 11) ? 1 : 0);
         chk("bp_push_n", 32'(bus.push_out_n), (c >= 8 && c <= 11) ? 0 : 1);
         if (c >= 4 && c <= 11) begin
            chk("bp_id", 32'(bus.arrive_id), 32'(exp_id));
            chk("bp_z",  32'(bus.z), 32'(2 * exp_id));
         end
         step();
      end

      // bubble collapse: 0xA at cycle 0, 0xB at cycle 2, release at cycle 6
      do_reset();
      for (int c = 0; c <= 8; c++) begin
         if (c == 0)      drive(8'd1, 8'd7, 1'b0, 8'h0A);
         else if (c == 2) drive(8'd2, 8'd7, 1'b0, 8'h0B);
         else             idle();
         bus.accept_n = (c >= 6) ? 1'b0 : 1'b1;
         #1;
         chk("bub_census", 32'(bus.pipe_census),
             (c == 0) ? 0 : (c <= 2) ? 1 : (c <= 6) ? 2 : (c == 7) ? 1 : 0);
         chk("bub_full",   32'(bus.pipe_full), 0);
         chk("bub_arrive", 32'(bus.arrive), (c >= 4 && c <= 7) ? 1 : 0);
         if (c >= 4 && c <= 7) begin
            chk("bub_id", 32'(bus.arrive_id), (c == 7) ? 32'h0B : 32'h0A);
            chk("bub_z",  32'(bus.z), (c == 7) ? 32'd14 : 32'd7);
         end
         step();
      end

      // full + drain + launch in the same cycle
      do_reset();
      for (int c = 0; c <= 9; c++) begin
         if (c <= 4) drive(8'(c + 1), 8'd1, 1'b0, 8'(8'h31 + c));
         else        idle();
         bus.accept_n = (c >= 4) ? 1'b0 : 1'b1;
         #1;
         if (c == 4) begin
            chk("fdl_full",   32'(bus.pipe_full), 0);
            chk("fdl_push_n", 32'(bus.push_out_n), 0);
         end
         if (c == 5) chk("fdl_ovf", 32'(bus.pipe_ovf), 0);
         if (c >= 4) begin
            chk("fdl_census", 32'(bus.pipe_census), (c <= 5) ? 4 : 32'(9 - c));
            chk("fdl_arrive", 32'(bus.arrive), (c <= 8) ? 1 : 0);
         end
         if (c >= 4 && c <= 8) chk("fdl_id", 32'(bus.arrive_id), 32'(8'h31 + c - 4));
         step();
      end

      // reset mid-operation
      do_reset();
      bus.accept_n = 1'b0;
      for (int c = 0; c <= 2; c++) begin
         drive(8'd9, 8'd9, 1'b0, 8'(8'h41 + c));
         step();
      end
      idle();
      #1;
      chk("mid_census_pre", 32'(bus.pipe_census), 3);
      rst = 1'b1;
      #1;
      chk("mid_census", 32'(bus.pipe_census), 0);
      chk("mid_arrive", 32'(bus.arrive), 0);
      chk("mid_full",   32'(bus.pipe_full), 0);
      chk("mid_ovf",    32'(bus.pipe_ovf), 0);
      chk("mid_push_n", 32'(bus.push_out_n), 1);
      chk("mid_z",      32'(bus.z), 0);
      chk("mid_id",     32'(bus.arrive_id), 0);
      step();
      rst = 1'b0;
      for (int c = 0; c < 10; c++) begin
         #1;
         chk("post_arrive", 32'(bus.arrive), 0);
         chk("post_census", 32'(bus.pipe_census), 0);
`ifdef LP_PIPED_INT_MULT_OUT_ISO_EN
         chk("post_iso_z", 32'(bus.z), 0);
`endif
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
